// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR run controller.
//   - State encoding for the controller FSM (IDLE, MAC, DRAIN, WRITE, DONE).
//   - acc_width(): accumulator width that cannot overflow for a given
//     sample width, coefficient width and tap count.
package fir_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_MAC   = 3'd1;
    localparam state_t ST_DRAIN = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Full-precision product plus log2(TAPS) guard bits.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_ctrl_if.sv
// fir_ctrl_if: memory-side bus of the FIR controller.
//   in_addr/in_data     : input sample RAM read port (1-cycle read latency)
//   coef_addr/coef_data : coefficient memory read port (1-cycle read latency)
//   out_addr/out_data/out_wr : output RAM write port
// master = controller, slave = memories.
interface fir_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 21,
    parameter int TAPS   = 32
);
    localparam int CA_W = $clog2(TAPS);

    logic        [ADDR_W-1:0] in_addr;
    logic signed [DATA_W-1:0] in_data;
    logic        [CA_W-1:0]   coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic        [ADDR_W-1:0] out_addr;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_wr;

    modport master (
        output in_addr, coef_addr, out_addr, out_data, out_wr,
        input  in_data, coef_data
    );

    modport slave (
        input  in_addr, coef_addr, out_addr, out_data, out_wr,
        output in_data, coef_data
    );
endinterface

// File: rtl/fir_mac.sv
// fir_mac: multiply-accumulate datapath of the FIR controller.
//   in_data, coef_data : RAM read data (already aligned with valid/zero/first)
//   valid              : a product is present this cycle
//   zero               : force the product to 0 (tap reaches before x[0])
//   first              : product loads the accumulator instead of adding
//   result             : sat(acc >>> SHIFT), combinational from the accumulator
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 21,
    parameter int TAPS   = 32,
    parameter int SHIFT  = 15
) (
    input  logic                     a_clk,
    input  logic                     a_rst_n,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     valid,
    input  logic                     zero,
    input  logic                     first,
    output logic signed [OUT_W-1:0]  result
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

    logic signed [PROD_W-1:0] x_ext, c_ext, prod, term;
    logic signed [ACC_W-1:0]  term_ext, acc, shifted;

    // Operands widened to the product width so the multiply is full precision.
    assign x_ext    = {{COEF_W{in_data[DATA_W-1]}}, in_data};
    assign c_ext    = {{DATA_W{coef_data[COEF_W-1]}}, coef_data};
    assign prod     = x_ext * c_ext;
    assign term     = zero ? '0 : prod;
    assign term_ext = {{(ACC_W-PROD_W){term[PROD_W-1]}}, term};

    always_ff @(posedge a_clk) begin
        if (!a_rst_n)
            acc <= '0;
        else if (valid)
            acc <= first ? term_ext : acc + term_ext;
    end

    assign shifted = acc >>> SHIFT;

    // In range when every bit from the output sign bit upward agrees.
    always_comb begin
        if ((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]))
            result = shifted[OUT_W-1:0];
        else if (shifted[ACC_W-1])
            result = {1'b1, {(OUT_W-1){1'b0}}};
        else
            result = {1'b0, {(OUT_W-1){1'b1}}};
    end

endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: FIR run controller. On start, computes
//   y[n] = sum_k h[k] * x[n-k], n = 0..N-1, writing sat(acc >>> SHIFT) to out RAM.
// Ports:
//   a_clk, a_rst_n : clock, synchronous active-low reset
//   start          : single-cycle run request (ignored while busy)
//   n_samples      : output count N (0..2^ADDR_W), latched on accepted start
//   busy           : high in every state but IDLE
//   done           : one-cycle completion pulse
//   ram            : memory bus (input/coef read ports, output write port)
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 21,
    parameter int TAPS   = 32,
    parameter int SHIFT  = 15
) (
    input  logic              a_clk,
    input  logic              a_rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   n_samples,
    output logic              busy,
    output logic              done,
    fir_ctrl_if.master        ram
);
    localparam int CA_W = $clog2(TAPS);

    state_t            state;
    logic [ADDR_W-1:0] n;
    logic [CA_W-1:0]   k;
    logic [ADDR_W:0]   n_total;

    logic issue, last_tap, last_out;
    logic vld_q, zero_q, first_q;
    logic signed [OUT_W-1:0] mac_result;

    assign issue    = (state == ST_MAC);
    assign last_tap = (k == CA_W'(TAPS - 1));
    assign last_out = ({1'b0, n} == n_total - (ADDR_W+1)'(1));

    always_ff @(posedge a_clk) begin
        if (!a_rst_n) begin
            state   <= ST_IDLE;
            n       <= '0;
            k       <= '0;
            n_total <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_total <= n_samples;
                        n       <= '0;
                        k       <= '0;
                        state   <= (n_samples == '0) ? ST_DONE : ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (last_tap) begin
                        k     <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        k <= k + CA_W'(1);
                    end
                end
                ST_DRAIN: state <= ST_WRITE;
                ST_WRITE: begin
                    if (last_out) begin
                        state <= ST_DONE;
                    end else begin
                        n     <= n + ADDR_W'(1);
                        k     <= '0;
                        state <= ST_MAC;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Issue qualifiers delayed one cycle to line up with the RAM read data.
    always_ff @(posedge a_clk) begin
        if (!a_rst_n) begin
            vld_q   <= 1'b0;
            zero_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            vld_q   <= issue;
            zero_q  <= (n < ADDR_W'(k));
            first_q <= (k == '0);
        end
    end

    fir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W),
        .TAPS   (TAPS),
        .SHIFT  (SHIFT)
    ) u_mac (
        .a_clk     (a_clk),
        .a_rst_n   (a_rst_n),
        .in_data   (ram.in_data),
        .coef_data (ram.coef_data),
        .valid     (vld_q),
        .zero      (zero_q),
        .first     (first_q),
        .result    (mac_result)
    );

    // n-k wraps modulo 2^ADDR_W for taps before x[0]; those products are zeroed.
    assign ram.in_addr   = n - ADDR_W'(k);
    assign ram.coef_addr = k;
    assign ram.out_wr    = (state == ST_WRITE);
    assign ram.out_addr  = n;
    assign ram.out_data  = ram.out_wr ? mac_result : '0;

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

FIR run controller. Once the AXI slave has filled the input sample RAM and the coefficient memory, `fir_ctrl` sequences the convolution. It reads samples and coefficients, accumulates the taps, scales and saturates each result, and writes it into the output RAM that AXI later reads back. It owns the read side of the input RAM and the write side of the output RAM while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 13: input/output RAM address width.
- `DATA_W`, 16: sample width, signed.
- `COEF_W`, 16: coefficient width, signed.
- `OUT_W`, 21: output sample width, signed.
- `TAPS`, 32: tap count, at least 2.
- `SHIFT`, 15: arithmetic right shift applied to the accumulator before saturation.

Ports:
- `a_clk`  in  1  clock.
- `a_rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle run request.
- `n_samples`  in  ADDR_W+1  number of output samples, 0..2^ADDR_W; latched on accepted `start`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle completion pulse.
- `in_addr`  out  ADDR_W  input RAM read address.
- `in_data`  in  DATA_W  input RAM read data, one-cycle latency.
- `coef_addr`  out  $clog2(TAPS)  coefficient read address.
- `coef_data`  in  COEF_W  coefficient data, one-cycle latency.
- `out_addr`  out  ADDR_W  output RAM write address.
- `out_data`  out  OUT_W  output RAM write data.
- `out_wr`  out  1  output RAM write strobe.

## Operation
- Computes y[n] = Σ_{k=0}^{TAPS-1} h[k]·x[n−k] for n = 0..N−1. Terms with n−k < 0 contribute zero; the input RAM is still addressed for them, but the product is forced to 0.
- State machine:
  - IDLE: `start` latches N. If N = 0, go to DONE; otherwise clear n and k and go to MAC.
  - MAC: issues `in_addr` = n−k (mod 2^ADDR_W) and `coef_addr` = k. k increments each cycle; after issuing k = TAPS−1, go to DRAIN.
  - DRAIN: the last product is accumulated; go to WRITE.
  - WRITE: `out_wr` = 1, `out_addr` = n, `out_data` = sat(acc >>> SHIFT). If n = N−1, go to DONE; else n++, k = 0, return to MAC.
  - DONE: `done` = 1 for one cycle, then go to IDLE.
- Issue pipeline:
  - An issue-valid bit and a zero flag (n < k) are delayed one cycle to align with the RAM data.
  - The first product of each output (k = 0) loads the accumulator; later products add to it.
- Arithmetic:
  - Product width is DATA_W+COEF_W, signed.
  - Accumulator width is ACC_W = DATA_W+COEF_W+$clog2(TAPS); it cannot overflow.
  - The shift is arithmetic (floor).
  - Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- `busy` is 1 in every state except IDLE.
- `start` while `busy` is ignored.
- Reset values: state IDLE; `busy`, `done`, `out_wr` = 0; all addresses and `out_data` = 0; accumulator 0.

## Timing
- `start` is sampled in cycle 0. MAC begins in cycle 1.
- Each output takes exactly TAPS+2 cycles (TAPS MAC, 1 DRAIN, 1 WRITE).
- `done` is high in cycle 1 + N·(TAPS+2); `busy` falls the cycle after that.
- N = 0: `done` is high in cycle 1, with no writes.
- Writes occur in strictly increasing `out_addr` order, one write per output.
- Reset asserted mid-run: the next edge returns to IDLE, with no further `out_wr` and no `done`. Data already written to the output RAM is not invalidated.
- `out_wr`, `out_addr` and `out_data` are valid together in the WRITE cycle only.

## Structure
- `fir_pkg`: the state enum (IDLE, MAC, DRAIN, WRITE, DONE) and a function returning ACC_W from the widths and tap count.
- Sub-module `fir_mac`: signed multiply, load/accumulate, arithmetic shift and saturation. Its inputs are `in_data`, `coef_data`, valid, zero and first.
- `fir_ctrl` holds the FSM and the n/k counters.

## Test plan
- Impulse coefficient: h[0] = 0x7FFF, other taps 0; x[0..3] = 100, 200, −100, 0; N = 4 → y = 99, 199, −100, 0 at addresses 0..3.
- Delay tap: h[3] = 0x7FFF only; x[0] = 1000, rest 0; N = 8 → y[3] = 999, all others 0; confirms zeroing of the n < k terms.
- Saturation: all h = −32768, all x = −32768, N = 40 → y[0] = 32768, y[30] = 1015808, y[31..39] = 0x0FFFFF.
- Timing: N = 2, TAPS = 32; `start` in cycle 0, plus a second `start` in cycle 10 → exactly 2 writes, in cycles 34 and 68; `done` in cycle 69; the second `start` is ignored.
- N = 0 → `done` in cycle 1, `busy` high for exactly one cycle, `out_wr` never asserted.
- Reset in cycle 40 of an N = 4 run → 1 write observed (cycle 34), no `done`; a new `start` after reset produces a correct full run.
